// File: rtl/multicycle_main_control_pkg.sv
// multicycle_main_control_pkg
//   Shared definitions for the multicycle MIPS main control FSM:
//   state encodings, opcode constants, ALUOp codes consumed by the ALU
//   control decoder, and the ALUSrcB / PCSource mux select encodings.
package multicycle_main_control_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXEC     = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    // ALUOp codes, shared with the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB mux selects.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSource mux selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the opcodes this controller knows how to execute.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode
//   Purely combinational state-to-control decoder for the multicycle
//   MIPS datapath. Every output is a function of the current state only,
//   except the FETCH-state PC and IR writes, which are qualified by the
//   memory-ready handshake so they fire only when the fetch completes.
// Ports:
//   state          in   current FSM state encoding
//   mem_ready      in   memory access completes this cycle
//   pc_write .. pc_source   out  datapath enables and mux selects
module multicycle_ctrl_decode
    import multicycle_main_control_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source
);

    always_comb begin
        // NOTE: every output gets a default before the case so that states
        // which do not mention a signal drive 0 rather than inferring a latch.
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC+4 and IR load only when the instruction word arrives.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed speculatively into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: ; // IDLE and unused encodings: all outputs 0
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
//   Main control FSM for the multicycle MIPS datapath (R-type, lw, sw,
//   beq, j, addi). Holds the state register, the next-state logic and a
//   sticky illegal-opcode flag; control outputs come from
//   multicycle_ctrl_decode.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   start_i             leave IDLE and begin fetching
//   Op_i                opcode from the instruction register
//   mem_ready_i         memory access completes this cycle
//   PCWrite_o .. PCSource_o   datapath enables / mux selects
//   illegal_o           sticky illegal-opcode flag (cleared by reset)
//   state_o             current state (debug)
module multicycle_main_control
    import multicycle_main_control_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         ALUOp_o,
    output logic [1:0]         PCSource_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t next_state;
    logic   illegal;
    logic   set_illegal;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;

        case (state)
            S_IDLE:     if (start_i) next_state = S_FETCH;
            S_FETCH:    if (mem_ready_i) next_state = S_DECODE;
            S_DECODE: begin
                case (Op_i)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    default:      next_state = S_FETCH;
                endcase
                // Unknown opcodes are flagged and skipped; fetch resumes.
                set_illegal = !is_legal_op(Op_i);
            end
            // Only lw/sw reach MEMADR, and the IR keeps Op_i stable.
            S_MEMADR:   next_state = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready_i) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWR:    if (mem_ready_i) next_state = S_FETCH;
            S_EXEC:     next_state = S_RTYPE_WB;
            S_RTYPE_WB: next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_ADDI_EX:  next_state = S_ADDI_WB;
            S_ADDI_WB:  next_state = S_FETCH;
            default:    next_state = S_IDLE; // unused encodings recover
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state         (state),
        .mem_ready     (mem_ready_i),
        .pc_write      (PCWrite_o),
        .pc_write_cond (PCWriteCond_o),
        .ior_d         (IorD_o),
        .mem_read      (MemRead_o),
        .mem_write     (MemWrite_o),
        .ir_write      (IRWrite_o),
        .mem_to_reg    (MemtoReg_o),
        .reg_dst       (RegDst_o),
        .reg_write     (RegWrite_o),
        .alu_src_a     (ALUSrcA_o),
        .alu_src_b     (ALUSrcB_o),
        .alu_op        (ALUOp_o),
        .pc_source     (PCSource_o)
    );

    assign illegal_o = illegal;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
//   Directed bench for the multicycle main control FSM. Control outputs
//   are packed into one 16-bit vector and compared against hand-derived
//   per-state constants:
//   {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//    RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]}
module tb_multicycle_main_control;

    // Expected control vectors, one per state.
    localparam logic [15:0] V_IDLE      = 16'h0000;
    localparam logic [15:0] V_FETCH     = 16'h9410; // PCWrite MemRead IRWrite SrcB=01
    localparam logic [15:0] V_FETCH_STL = 16'h1010; // MemRead SrcB=01
    localparam logic [15:0] V_DECODE    = 16'h0030; // SrcB=11
    localparam logic [15:0] V_MEMADR    = 16'h0060; // SrcA=1 SrcB=10
    localparam logic [15:0] V_MEMRD     = 16'h3000; // IorD MemRead
    localparam logic [15:0] V_MEMWB     = 16'h0280; // MemtoReg RegWrite
    localparam logic [15:0] V_MEMWR     = 16'h2800; // IorD MemWrite
    localparam logic [15:0] V_EXEC      = 16'h0048; // SrcA=1 ALUOp=10
    localparam logic [15:0] V_RTYPE_WB  = 16'h0180; // RegDst RegWrite
    localparam logic [15:0] V_BRANCH    = 16'h4045; // PCWriteCond SrcA ALUOp=01 PCSrc=01
    localparam logic [15:0] V_JUMP      = 16'h8002; // PCWrite PCSrc=10
    localparam logic [15:0] V_ADDI_EX   = 16'h0060;
    localparam logic [15:0] V_ADDI_WB   = 16'h0080; // RegWrite

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] op;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal;
    logic [3:0] state;

    int total_checks  = 0;
    int failed_checks = 0;

    multicycle_main_control dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .Op_i          (op),
        .mem_ready_i   (mem_ready),
        .PCWrite_o     (pc_write),
        .PCWriteCond_o (pc_write_cond),
        .IorD_o        (ior_d),
        .MemRead_o     (mem_read),
        .MemWrite_o    (mem_write),
        .IRWrite_o     (ir_write),
        .MemtoReg_o    (mem_to_reg),
        .RegDst_o      (reg_dst),
        .RegWrite_o    (reg_write),
        .ALUSrcA_o     (alu_src_a),
        .ALUSrcB_o     (alu_src_b),
        .ALUOp_o       (alu_op),
        .PCSource_o    (pc_source),
        .illegal_o     (illegal),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ctrl_vec();
        return {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            failed_checks++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state and full control vector together.
    task automatic expect_state(input string tag, input logic [3:0] st,
                                input logic [15:0] vec);
        check({tag, ".state"}, {28'd0, state}, {28'd0, st});
        check({tag, ".ctrl"},  {16'd0, ctrl_vec()}, {16'd0, vec});
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b1;

        // Reset, then release with start low: stays in IDLE.
        tick();
        tick();
        expect_state("reset", 4'd0, V_IDLE);
        check("reset.illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        tick();
        expect_state("idle_hold", 4'd0, V_IDLE);

        // One-cycle start pulse -> FETCH with ready high.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_state("fetch", 4'd1, V_FETCH);

        // One-cycle fetch stall: writes drop, state holds.
        mem_ready = 1'b0;
        #1;
        check("fetch_stall.ctrl", {16'd0, ctrl_vec()}, {16'd0, V_FETCH_STL});
        tick();
        expect_state("fetch_stall", 4'd1, V_FETCH_STL);
        mem_ready = 1'b1;
        #1;

        // R-type: 1,2,7,8,1
        op = 6'b000000;
        tick(); expect_state("rtype.decode", 4'd2, V_DECODE);
        tick(); expect_state("rtype.exec",   4'd7, V_EXEC);
        tick(); expect_state("rtype.wb",     4'd8, V_RTYPE_WB);
        tick(); expect_state("rtype.fetch",  4'd1, V_FETCH);

        // lw with two stall cycles in MEMRD: 1,2,3,4,4,4,5,1
        op = 6'b100011;
        tick(); expect_state("lw.decode", 4'd2, V_DECODE);
        tick(); expect_state("lw.memadr", 4'd3, V_MEMADR);
        tick(); expect_state("lw.memrd0", 4'd4, V_MEMRD);
        mem_ready = 1'b0;
        tick(); expect_state("lw.memrd1", 4'd4, V_MEMRD);
        tick(); expect_state("lw.memrd2", 4'd4, V_MEMRD);
        mem_ready = 1'b1;
        tick(); expect_state("lw.memwb",  4'd5, V_MEMWB);
        tick(); expect_state("lw.fetch",  4'd1, V_FETCH);

        // beq: 1,2,9,1
        op = 6'b000100;
        tick(); expect_state("beq.decode", 4'd2, V_DECODE);
        tick(); expect_state("beq.branch", 4'd9, V_BRANCH);
        tick(); expect_state("beq.fetch",  4'd1, V_FETCH);

        // j: 1,2,10,1
        op = 6'b000010;
        tick(); expect_state("j.decode", 4'd2, V_DECODE);
        tick(); expect_state("j.jump",   4'd10, V_JUMP);
        tick(); expect_state("j.fetch",  4'd1, V_FETCH);

        // Illegal opcode: back to FETCH, flag sets at the DECODE edge.
        op = 6'b111111;
        tick(); expect_state("ill.decode", 4'd2, V_DECODE);
        check("ill.pre_flag", {31'd0, illegal}, 32'd0);
        tick(); expect_state("ill.fetch", 4'd1, V_FETCH);
        check("ill.flag", {31'd0, illegal}, 32'd1);

        // addi after the illegal op: 1,2,11,12,1 and flag stays set.
        op = 6'b001000;
        tick(); expect_state("addi.decode", 4'd2, V_DECODE);
        tick(); expect_state("addi.ex",     4'd11, V_ADDI_EX);
        tick(); expect_state("addi.wb",     4'd12, V_ADDI_WB);
        tick(); expect_state("addi.fetch",  4'd1, V_FETCH);
        check("addi.flag_sticky", {31'd0, illegal}, 32'd1);

        // sw, stall in MEMWR, then reset mid-stall.
        op = 6'b101011;
        tick(); expect_state("sw.decode", 4'd2, V_DECODE);
        tick(); expect_state("sw.memadr", 4'd3, V_MEMADR);
        tick(); expect_state("sw.memwr0", 4'd6, V_MEMWR);
        mem_ready = 1'b0;
        tick(); expect_state("sw.memwr1", 4'd6, V_MEMWR);
        rst_n = 1'b0;
        tick(); expect_state("sw.reset", 4'd0, V_IDLE);
        check("sw.reset.illegal", {31'd0, illegal}, 32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        tick(); expect_state("post_reset.idle0", 4'd0, V_IDLE);
        tick(); expect_state("post_reset.idle1", 4'd0, V_IDLE);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU control decoder: decodes the instruction opcode over several cycles and drives every datapath enable/mux select, including the 2-bit ALUOp the ALU control decoder consumes (00 add, 01 sub, 10 use funct). Supports R-type, lw, sw, beq, j and addi. Stalls on a memory-ready handshake.

Parameters:
OP_W, 6, opcode width
STATE_W, 4, state register width

Ports:
clk_i  input  1  clock
rst_n_i  input  1  synchronous active-low reset
start_i  input  1  leave IDLE and begin fetching
Op_i  input  6  opcode field from instruction register
mem_ready_i  input  1  memory access completes this cycle
PCWrite_o  output  1  unconditional PC write
PCWriteCond_o  output  1  PC write if ALU zero
IorD_o  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead_o  output  1  memory read
MemWrite_o  output  1  memory write
IRWrite_o  output  1  instruction register load
MemtoReg_o  output  1  0 = ALUOut, 1 = MDR to register file
RegDst_o  output  1  0 = rt, 1 = rd
RegWrite_o  output  1  register file write
ALUSrcA_o  output  1  0 = PC, 1 = reg A
ALUSrcB_o  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp_o  output  2  to ALU control decoder
PCSource_o  output  2  00 ALU result, 01 ALUOut, 10 jump target
illegal_o  output  1  sticky illegal-opcode flag
state_o  output  4  current state (debug)

Behaviour:
- Reset (rst_n_i low at a clk_i edge): state becomes IDLE and illegal_o clears. This overrides all other activity, including mid-instruction and mid-stall; no writes are asserted after that edge.
- Outputs are decoded from the state register. Exception: PCWrite_o and IRWrite_o in FETCH are additionally ANDed with mem_ready_i. Any output not listed for a state is 0.
- IDLE (0): all outputs 0. Goes to FETCH when start_i=1. start_i is ignored in every other state.
- FETCH (1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready_i. Stays in FETCH while mem_ready_i=0; goes to DECODE when it is 1.
- DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by Op_i:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - any other value -> FETCH, and illegal_o is set to 1 at that edge.
- MEMADR (3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD (4): MemRead=1, IorD=1. Waits for mem_ready_i, then -> MEMWB.
- MEMWB (5): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR (6): MemWrite=1, IorD=1. Waits for mem_ready_i, then -> FETCH.
- EXEC (7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPE_WB.
- RTYPE_WB (8): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP (10): PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EX (11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
- ADDI_WB (12): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Unused encodings 13-15 go to IDLE on the next edge with all outputs 0.
- Latency with mem_ready_i tied to 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each cycle mem_ready_i is low in FETCH/MEMRD/MEMWR adds 1 cycle.
- Op_i is sampled only in DECODE and MEMADR; the IR holds it stable from the end of FETCH.
- illegal_o stays 1 until reset; execution continues with the next fetch.

Decomposition:
- Shared package holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp codes (ADD=00, SUB=01, FUNCT=10), shared with the ALU control decoder
  - ALUSrcB and PCSource select encodings
- One natural sub-module: multicycle_ctrl_decode, a pure combinational state-to-outputs decoder. The FSM module keeps the state register and next-state logic.

Test Plan:
- Reset with start_i=0 -> state_o=0 and all outputs 0. Assert start_i for 1 cycle -> state_o=1, MemRead_o=1, ALUSrcB_o=01, IRWrite_o=PCWrite_o=1 (mem_ready_i=1).
- Op_i=000000, mem_ready_i=1 -> states 1,2,7,8,1. ALUOp_o=10 in state 7. RegWrite_o=RegDst_o=1 in state 8.
- Op_i=100011 with mem_ready_i low for 2 cycles in MEMRD -> states 1,2,3,4,4,4,5,1. MemtoReg_o=1 and RegWrite_o=1 only in state 5.
- Op_i=000100 -> states 1,2,9,1; ALUOp_o=01, PCWriteCond_o=1, PCSource_o=01 in state 9. Op_i=000010 -> states 1,2,10,1; PCWrite_o=1, PCSource_o=10 in state 10.
- Op_i=111111 in DECODE -> next state 1, illegal_o=1 and still 1 after a following addi (Op_i=001000: states 1,2,11,12,1).
- rst_n_i low during MEMWR stall (mem_ready_i=0) -> next edge state_o=0, MemWrite_o=0, illegal_o=0. With start_i=0 the FSM stays in IDLE.
